// File: rtl/fifo_read_prefetch_pkg.sv
// Shared definitions for FIFO read connectors: width helper and the legal
// source read-latency range.
package fifo_read_prefetch_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit rd_latency_legal(input int latency);
        return (latency >= RD_LATENCY_MIN) && (latency <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Circular prefetch buffer holding words returned by the source FIFO.
// Depth need not be a power of two, so pointers wrap on an explicit compare.
module fifo_prefetch_buf
    import fifo_read_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        din,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic [clog2(DEPTH+1)-1:0]    count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is left uncleared by reset; count alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_prefetch.sv
// Converts a fixed-latency standard source FIFO into a first-word-fall-through
// read port; reads are issued only against free prefetch credits.
module fifo_read_prefetch
    import fifo_read_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_WIDTH-1:0] din_src,
    output logic                  rd_en_src,
    input  logic                  empty_src,
    output logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic                  empty_n
);

    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int CW        = clog2(BUF_DEPTH + 1);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("fifo_read_prefetch: RD_LATENCY must be in 1..3");
    end

    logic [RD_LATENCY-1:0] vpipe;
    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic [CW:0]           credit_used;
    logic                  capture;
    logic                  pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
    end

    // Credits come only from registered state, so rd_en never reaches rd_en_src.
    assign credit_used = {1'b0, count} + {1'b0, inflight};
    assign rd_en_src   = !ap_rst && !empty_src && (credit_used < (CW+1)'(BUF_DEPTH));
    assign capture     = vpipe[RD_LATENCY-1];

    // Consumer handshake: din is valid whenever empty_n=1; a word is taken on
    // any rising edge where rd_en=1 and empty_n=1. rd_en with empty_n=0 is ignored.
    assign empty_n = (count != '0);
    assign pop     = rd_en && empty_n;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= RD_LATENCY'({vpipe, rd_en_src});
        end
    end

    fifo_prefetch_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (BUF_DEPTH)
    ) u_buf (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .push (capture),
        .pop  (pop),
        .din  (din_src),
        .dout (din),
        .count(count)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            assert (!(capture && (count == CW'(BUF_DEPTH))));
            assert (credit_used <= (CW+1)'(BUF_DEPTH));
        end
    end

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Bench for fifo_read_prefetch: three lanes at read latencies 1, 2 and 3, each
// fed by a fixed-latency source model and checked by an in-order scoreboard.
module tb_fifo_read_prefetch;

    localparam int W        = 32;
    localparam int LANES    = 3;
    localparam int SRC_SIZE = 1024;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst = 1'b1;
    logic [LANES-1:0]          rd_en_src;
    logic [LANES-1:0]          empty_src;
    logic [LANES-1:0]          rd_en;
    logic [LANES-1:0]          empty_n;
    logic [LANES-1:0]          src_block;
    logic [LANES-1:0][W-1:0]   din_src;
    logic [LANES-1:0][W-1:0]   din;
    logic [W-1:0]              src_mem [LANES][SRC_SIZE];
    int                        src_wr [LANES];
    int                        n_vec = 0;
    int                        n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- lanes: DUT, source model, monitor ----------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int LAT   = g + 1;
        localparam int DEPTH = LAT + 2;

        logic [W-1:0] exp_q[$];
        logic [W-1:0] pipe [LAT];
        int           src_rd = 0;
        int           issued = 0;
        int           popped = 0;

        fifo_read_prefetch #(
            .DATA_WIDTH(W),
            .RD_LATENCY(LAT)
        ) dut (
            .ap_clk   (ap_clk),
            .ap_rst   (ap_rst),
            .din_src  (din_src[g]),
            .rd_en_src(rd_en_src[g]),
            .empty_src(empty_src[g]),
            .din      (din[g]),
            .rd_en    (rd_en[g]),
            .empty_n  (empty_n[g])
        );

        assign empty_src[g] = src_block[g] || (src_rd >= src_wr[g]);
        assign din_src[g]   = pipe[LAT-1];

        // Standard FIFO: the word read at an edge appears LAT cycles later.
        always @(posedge ap_clk) begin
            if (ap_rst) src_rd <= 0;
            else if (rd_en_src[g]) src_rd <= src_rd + 1;
            pipe[0] <= rd_en_src[g] ? src_mem[g][src_rd % SRC_SIZE] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        always @(negedge ap_clk) begin
            if (ap_rst) begin
                issued = 0;
                popped = 0;
            end else begin
                if (empty_n[g] && rd_en[g]) begin
                    popped++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL lane%0d pop_unexpected: got %0h, required no word", g, din[g]);
                    end else begin
                        check($sformatf("lane%0d pop_data", g), din[g], exp_q.pop_front());
                    end
                end
                if (rd_en_src[g]) begin
                    issued++;
                    check($sformatf("lane%0d credit_bound", g), W'(issued - popped <= DEPTH), W'(1));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge ap_clk);
    endtask

    task automatic push_exp(input int g, input logic [W-1:0] w);
        case (g)
            0:       g_lane[0].exp_q.push_back(w);
            1:       g_lane[1].exp_q.push_back(w);
            default: g_lane[2].exp_q.push_back(w);
        endcase
    endtask

    task automatic clear_exp();
        g_lane[0].exp_q.delete();
        g_lane[1].exp_q.delete();
        g_lane[2].exp_q.delete();
    endtask

    function automatic int exp_left();
        return g_lane[0].exp_q.size() + g_lane[1].exp_q.size() + g_lane[2].exp_q.size();
    endfunction

    task automatic load_all(input logic [W-1:0] base, input int n, input bit rand_data);
        logic [W-1:0] w;
        for (int g = 0; g < LANES; g++) begin
            for (int i = 0; i < n; i++) begin
                w = rand_data ? W'($urandom) : base + W'(i);
                src_mem[g][(src_wr[g] + i) % SRC_SIZE] = w;
                push_exp(g, w);
            end
            src_wr[g] = src_wr[g] + n;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first [LANES];
        int last  [LANES];
        int pops  [LANES];
        int cyc;
        int lat;
        int n_issue;

        rd_en     = '0;
        src_block = '0;
        for (int g = 0; g < LANES; g++) src_wr[g] = 0;
        ap_rst = 1'b1;
        repeat (2) tick();

        // Reset state.
        sample();
        for (int g = 0; g < LANES; g++) begin
            check($sformatf("lane%0d reset_rd_en_src", g), W'(rd_en_src[g]), W'(0));
            check($sformatf("lane%0d reset_empty_n", g), W'(empty_n[g]), W'(0));
        end
        tick();
        ap_rst = 1'b0;

        // Popping an empty adapter with an empty source.
        rd_en = '1;
        for (int c = 0; c < 10; c++) begin
            sample();
            for (int g = 0; g < LANES; g++) begin
                check($sformatf("lane%0d idle_rd_en_src", g), W'(rd_en_src[g]), W'(0));
                check($sformatf("lane%0d idle_empty_n", g), W'(empty_n[g]), W'(0));
            end
            tick();
        end
        rd_en = '0;

        // Fill with no consumer: issues stop at BUF_DEPTH credits or source empty.
        load_all(32'hA0, 4, 1'b0);
        for (int k = 0; k < 8; k++) begin
            sample();
            for (int g = 0; g < LANES; g++) begin
                lat     = g + 1;
                n_issue = (lat + 2 < 4) ? lat + 2 : 4;
                check($sformatf("lane%0d fill_rd_en_src k%0d", g, k), W'(rd_en_src[g]), W'(k < n_issue));
                check($sformatf("lane%0d fill_empty_n k%0d", g, k), W'(empty_n[g]), W'(k >= lat + 1));
                if (k >= lat + 1) check($sformatf("lane%0d fill_head k%0d", g, k), din[g], 32'hA0);
            end
            tick();
        end
        rd_en = '1;
        repeat (12) tick();
        check("fill_drained", W'(exp_left()), W'(0));

        // Streaming: 100 words, consumer always ready, expect no gaps.
        load_all(32'h0, 100, 1'b0);
        for (int g = 0; g < LANES; g++) begin
            first[g] = -1;
            last[g]  = -1;
            pops[g]  = 0;
        end
        for (int c = 0; c < 200; c++) begin
            sample();
            for (int g = 0; g < LANES; g++) begin
                if (empty_n[g]) begin
                    if (first[g] < 0) first[g] = c;
                    last[g] = c;
                    pops[g]++;
                end
            end
            tick();
        end
        for (int g = 0; g < LANES; g++) begin
            check($sformatf("lane%0d stream_count", g), W'(pops[g]), W'(100));
            check($sformatf("lane%0d stream_span", g), W'(last[g] - first[g]), W'(99));
        end

        // Pointer wrap: 7-word bursts, alternating fill and drain windows.
        rd_en = '0;
        for (int r = 0; r < 3; r++) begin
            load_all(32'h100 * (r + 1), 7, 1'b0);
            cyc = 0;
            while (exp_left() != 0 && cyc < 200) begin
                rd_en = ((cyc / 4) % 2 == 1) ? '1 : '0;
                tick();
                cyc++;
            end
            check($sformatf("wrap_round%0d_drained", r), W'(exp_left()), W'(0));
        end

        // Irregular source availability and consumer.
        load_all(32'h0, 300, 1'b1);
        cyc = 0;
        while (exp_left() != 0 && cyc < 5000) begin
            for (int g = 0; g < LANES; g++) begin
                src_block[g] = ($urandom_range(0, 2) == 0);
                rd_en[g]     = ($urandom_range(0, 1) == 1);
            end
            tick();
            cyc++;
        end
        check("random_drained", W'(exp_left()), W'(0));
        src_block = '0;
        rd_en     = '0;

        // Reset with words in flight and buffered.
        load_all(32'h5000, 20, 1'b0);
        repeat (4) tick();
        ap_rst = 1'b1;
        sample();
        for (int g = 0; g < LANES; g++) begin
            check($sformatf("lane%0d rst_gates_rd_en_src", g), W'(rd_en_src[g]), W'(0));
        end
        tick();
        ap_rst = 1'b0;
        for (int g = 0; g < LANES; g++) src_wr[g] = 0;
        clear_exp();
        sample();
        for (int g = 0; g < LANES; g++) begin
            check($sformatf("lane%0d post_rst_empty_n", g), W'(empty_n[g]), W'(0));
            check($sformatf("lane%0d post_rst_rd_en_src", g), W'(rd_en_src[g]), W'(0));
        end
        tick();
        load_all(32'h7000, 6, 1'b0);
        rd_en = '1;
        repeat (20) tick();
        check("post_rst_drained", W'(exp_left()), W'(0));
        sample();
        for (int g = 0; g < LANES; g++) begin
            check($sformatf("lane%0d final_empty_n", g), W'(empty_n[g]), W'(0));
        end

        // Final report.
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
